// File: rtl/switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer_pkg
// Purpose  : Shared defaults and counter-width helper for the switch debouncer
// Revision : 1.0 - initial release
// ============================================================================
package switch_debouncer_pkg;

    localparam int DEBOUNCE_WIDTH  = 2;
    localparam int DEBOUNCE_CYCLES = 4;

    // Width of a counter that must hold 0..n-1; floored at 1 bit so a
    // degenerate n still yields a legal vector.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer_if
// Purpose  : Raw switch levels in, debounced levels and edge pulses out
// Revision : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH = DEBOUNCE_WIDTH
);
    logic [WIDTH-1:0] I;
    logic [WIDTH-1:0] O;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;

    modport master (output I, input O, input RISE, input FALL);
    modport slave  (input I, output O, output RISE, output FALL);
endinterface
`default_nettype wire

// File: rtl/switch_debouncer_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Purpose  : One-bit two-flop synchronizer, stability counter, level and
//            registered rise/fall pulse outputs
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_raw,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    localparam int               CNT_W     = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any agreement with the current level restarts the count, so
            // only an unbroken run of disagreement moves the output.
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= r_s2;
                r_cnt   <= '0;
                r_rise  <= r_s2;
                r_fall  <= ~r_s2;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Purpose  : WIDTH independent switch synchronizer/debouncers with edge pulses
// Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH         = DEBOUNCE_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    switch_debouncer_if.slave  bus
);

    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    assign w_in = bus.I;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_debounce_bit (
            .clk     (CLK),
            .rst     (RESET),
            .i_raw   (w_in[b]),
            .o_level (w_level[b]),
            .o_rise  (w_rise[b]),
            .o_fall  (w_fall[b])
        );
    end

    assign bus.O    = w_level;
    assign bus.RISE = w_rise;
    assign bus.FALL = w_fall;

endmodule
`default_nettype wire
